// File: rtl/pcie_tlp_pkg.sv
// rtl/pcie_tlp_pkg.sv - shared TLP header constants and completion helper functions
package pcie_tlp_pkg;

  // {fmt[1:0], type[4:0]} codes as they appear in DW0[30:24]
  localparam logic [6:0] FMT_TYPE_MRD32 = 7'b0000000;
  localparam logic [6:0] FMT_TYPE_CPLD  = 7'b1001010;

  // Completion status codes carried in CplD DW1[15:13]
  localparam logic [2:0] CPL_STATUS_SC  = 3'b000;
  localparam logic [2:0] CPL_STATUS_UR  = 3'b001;
  localparam logic [2:0] CPL_STATUS_CRS = 3'b010;
  localparam logic [2:0] CPL_STATUS_CA  = 3'b100;

  // Byte count of a single-DW read from its first byte enables; an empty
  // BE still reports one byte.
  function automatic logic [11:0] be_byte_count(input logic [3:0] be);
    logic [11:0] bc;
    casez (be)
      4'b1??1:                   bc = 12'd4;
      4'b01?1, 4'b1?10:          bc = 12'd3;
      4'b0011, 4'b0110, 4'b1100: bc = 12'd2;
      default:                   bc = 12'd1;
    endcase
    return bc;
  endfunction

  // Byte offset of the first enabled byte, feeding lower_addr[1:0]
  function automatic logic [1:0] be_lower_ofs(input logic [3:0] be);
    logic [1:0] ofs;
    casez (be)
      4'b???1: ofs = 2'd0;
      4'b??10: ofs = 2'd1;
      4'b?100: ofs = 2'd2;
      4'b1000: ofs = 2'd3;
      default: ofs = 2'd0;
    endcase
    return ofs;
  endfunction

endpackage

// File: rtl/cpld_byte_count.sv
// rtl/cpld_byte_count.sv - combinational first-BE decode for completion byte count and lower address
module cpld_byte_count
  import pcie_tlp_pkg::*;
(
  input  logic [3:0]  first_be,
  output logic [11:0] byte_count,
  output logic [1:0]  lower_ofs
);

  // Pure decode of the latched first BE
  always_comb begin
    byte_count = be_byte_count(first_be);
    lower_ofs  = be_lower_ofs(first_be);
  end

endmodule

// File: rtl/bar_rd_completer.sv
// rtl/bar_rd_completer.sv - BAR register completer turning MRd32 requests into 3DW CplD
module bar_rd_completer
  import pcie_tlp_pkg::*;
#(
  parameter int BAR_INDEX      = 0,
  parameter int REG_ADDR_W     = 10,
  parameter int REG_RD_LATENCY = 2
) (
  input  logic                  trn_clk,
  input  logic                  trn_reset,
  input  logic                  trn_lnk_up_n,
  input  logic [63:0]           trn_rd,
  input  logic [7:0]            trn_rrem_n,
  input  logic                  trn_rsof_n,
  input  logic                  trn_reof_n,
  input  logic                  trn_rsrc_rdy_n,
  input  logic                  trn_rsrc_dsc_n,
  input  logic [6:0]            trn_rbar_hit_n,
  output logic                  trn_rdst_rdy_n,
  output logic [63:0]           trn_td,
  output logic [7:0]            trn_trem_n,
  output logic                  trn_tsof_n,
  output logic                  trn_teof_n,
  output logic                  trn_tsrc_rdy_n,
  input  logic                  trn_tdst_rdy_n,
  input  logic [3:0]            trn_tbuf_av,
  input  logic [15:0]           cfg_completer_id,
  output logic                  tx_req,
  input  logic                  tx_gnt,
  output logic                  reg_rd_en,
  output logic [REG_ADDR_W-1:0] reg_rd_addr,
  input  logic [31:0]           reg_rd_data,
  output logic                  unsupported_req
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR2 = 3'd1,
    RD   = 3'd2,
    ARB  = 3'd3,
    TX0  = 3'd4,
    TX1  = 3'd5
  } state_t;

  localparam logic [2:0] LAT = 3'(REG_RD_LATENCY);

  state_t      state;
  state_t      state_nxt;
  logic        rst;
  logic        rx_beat;
  logic        rd_sof;
  logic        mrd_ok;
  logic [2:0]  tc_q;
  logic [1:0]  attr_q;
  logic [15:0] req_id_q;
  logic [7:0]  tag_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [2:0]  lat_cnt;
  logic [11:0] byte_count;
  logic [1:0]  lower_ofs;
  logic [31:0] cpl_dw0;
  logic [31:0] cpl_dw1;
  logic [31:0] cpl_dw2;
  logic [31:0] cpl_data;
  logic        unused_bits;

  // Link down behaves exactly like reset
  assign rst     = trn_reset | trn_lnk_up_n;
  assign rx_beat = !trn_rsrc_rdy_n && !trn_rdst_rdy_n;

  // A data-less request (fmt[1]=0) hitting our BAR is a read we must answer or reject
  assign rd_sof = rx_beat && !trn_rsof_n && !trn_rbar_hit_n[BAR_INDEX] && !trn_rd[62];
  assign mrd_ok = rd_sof && (trn_rd[62:56] == FMT_TYPE_MRD32)
                  && (trn_rd[41:32] == 10'd1) && !trn_rd[47];

  // Rx is stalled for the whole time a read is in flight so only one is ever outstanding
  assign trn_rdst_rdy_n = (state == RD) || (state == ARB) || (state == TX0) || (state == TX1);
  assign reg_rd_addr    = addr_q[REG_ADDR_W+1:2];

  cpld_byte_count u_byte_count (
    .first_be   (be_q),
    .byte_count (byte_count),
    .lower_ofs  (lower_ofs)
  );

  assign cpl_dw0  = {1'b0, FMT_TYPE_CPLD, 1'b0, tc_q, 4'b0, 1'b0, 1'b0, attr_q, 2'b0, 10'd1};
  assign cpl_dw1  = {cfg_completer_id, CPL_STATUS_SC, 1'b0, byte_count};
  assign cpl_dw2  = {req_id_q, tag_q, 1'b0, addr_q[6:2], lower_ofs};
  assign cpl_data = {data_q[7:0], data_q[15:8], data_q[23:16], data_q[31:24]};

  assign unused_bits = ^{trn_rrem_n, trn_tbuf_av, trn_rbar_hit_n, addr_q};

  // State register
  always_ff @(posedge trn_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Request field capture, register-latency counter and reject pulse
  always_ff @(posedge trn_clk) begin
    if (rst) begin
      tc_q            <= '0;
      attr_q          <= '0;
      req_id_q        <= '0;
      tag_q           <= '0;
      be_q            <= '0;
      addr_q          <= '0;
      data_q          <= '0;
      lat_cnt         <= '0;
      unsupported_req <= 1'b0;
    end else begin
      unsupported_req <= (state == IDLE) && rd_sof && !mrd_ok;
      if (state == IDLE && mrd_ok) begin
        tc_q     <= trn_rd[54:52];
        attr_q   <= trn_rd[45:44];
        req_id_q <= trn_rd[31:16];
        tag_q    <= trn_rd[15:8];
        be_q     <= trn_rd[3:0];
      end
      if (state == HDR2 && rx_beat) addr_q <= trn_rd[63:32];
      if (state == RD) begin
        lat_cnt <= lat_cnt + 3'd1;
        if (lat_cnt == LAT) data_q <= reg_rd_data;
      end else begin
        lat_cnt <= '0;
      end
    end
  end

  // Next state and Tx/register-port outputs
  always_comb begin
    state_nxt      = state;
    trn_tsof_n     = 1'b1;
    trn_teof_n     = 1'b1;
    trn_tsrc_rdy_n = 1'b1;
    trn_td         = '0;
    trn_trem_n     = 8'hFF;
    tx_req         = 1'b0;
    reg_rd_en      = 1'b0;
    case (state)
      IDLE: begin
        if (mrd_ok) state_nxt = HDR2;
      end
      HDR2: begin
        // A discontinued or over-long request is abandoned without a reply
        if (!trn_rsrc_dsc_n)  state_nxt = IDLE;
        else if (rx_beat)     state_nxt = trn_reof_n ? IDLE : RD;
      end
      RD: begin
        reg_rd_en = (lat_cnt == 3'd0);
        if (lat_cnt == LAT) state_nxt = ARB;
      end
      ARB: begin
        tx_req = 1'b1;
        if (tx_gnt && trn_tbuf_av[2]) state_nxt = TX0;
      end
      TX0: begin
        tx_req         = 1'b1;
        trn_tsof_n     = 1'b0;
        trn_tsrc_rdy_n = 1'b0;
        trn_td         = {cpl_dw0, cpl_dw1};
        if (!trn_tdst_rdy_n) state_nxt = TX1;
      end
      TX1: begin
        tx_req         = 1'b1;
        trn_teof_n     = 1'b0;
        trn_tsrc_rdy_n = 1'b0;
        trn_trem_n     = 8'h00;
        trn_td         = {cpl_dw2, cpl_data};
        if (!trn_tdst_rdy_n) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bar_rd_completer.sv
// tb/tb_bar_rd_completer.sv - self-checking bench for bar_rd_completer
module tb_bar_rd_completer;

  localparam int L = 2;
  localparam logic [6:0] FT_MRD32 = 7'h00;
  localparam logic [6:0] FT_MRD64 = 7'h20;
  localparam logic [6:0] FT_MWR32 = 7'h40;

  logic        trn_clk = 1'b0;
  logic        trn_reset;
  logic        trn_lnk_up_n;
  logic [63:0] trn_rd;
  logic [7:0]  trn_rrem_n;
  logic        trn_rsof_n;
  logic        trn_reof_n;
  logic        trn_rsrc_rdy_n;
  logic        trn_rsrc_dsc_n;
  logic [6:0]  trn_rbar_hit_n;
  logic        trn_rdst_rdy_n;
  logic [63:0] trn_td;
  logic [7:0]  trn_trem_n;
  logic        trn_tsof_n;
  logic        trn_teof_n;
  logic        trn_tsrc_rdy_n;
  logic        trn_tdst_rdy_n;
  logic [3:0]  trn_tbuf_av;
  logic [15:0] cfg_completer_id;
  logic        tx_req;
  logic        tx_gnt;
  logic        reg_rd_en;
  logic [9:0]  reg_rd_addr;
  logic [31:0] reg_rd_data;
  logic        unsupported_req;

  int checks = 0;
  int errors = 0;
  int ur_cnt = 0;
  int tx_cnt = 0;
  int rd_cnt = 0;
  int exp_reads = 0;
  logic [31:0] regs [1024];
  logic        pv [8];
  logic [9:0]  pa [8];

  always #5 trn_clk = ~trn_clk;

  bar_rd_completer #(.BAR_INDEX(0), .REG_ADDR_W(10), .REG_RD_LATENCY(L)) dut (
    .trn_clk(trn_clk), .trn_reset(trn_reset), .trn_lnk_up_n(trn_lnk_up_n),
    .trn_rd(trn_rd), .trn_rrem_n(trn_rrem_n), .trn_rsof_n(trn_rsof_n),
    .trn_reof_n(trn_reof_n), .trn_rsrc_rdy_n(trn_rsrc_rdy_n),
    .trn_rsrc_dsc_n(trn_rsrc_dsc_n), .trn_rbar_hit_n(trn_rbar_hit_n),
    .trn_rdst_rdy_n(trn_rdst_rdy_n), .trn_td(trn_td), .trn_trem_n(trn_trem_n),
    .trn_tsof_n(trn_tsof_n), .trn_teof_n(trn_teof_n), .trn_tsrc_rdy_n(trn_tsrc_rdy_n),
    .trn_tdst_rdy_n(trn_tdst_rdy_n), .trn_tbuf_av(trn_tbuf_av),
    .cfg_completer_id(cfg_completer_id), .tx_req(tx_req), .tx_gnt(tx_gnt),
    .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
    .unsupported_req(unsupported_req)
  );

  // Register port model: data for a strobe appears exactly L cycles later, junk otherwise
  always @(negedge trn_clk) begin
    for (int i = 7; i > 0; i--) begin
      pv[i] = pv[i-1];
      pa[i] = pa[i-1];
    end
    pv[0] = (reg_rd_en === 1'b1);
    pa[0] = reg_rd_addr;
    reg_rd_data = pv[L] ? regs[pa[L]] : $urandom;
  end

  // Activity counters
  always @(negedge trn_clk) begin
    if (unsupported_req === 1'b1) ur_cnt++;
    if (trn_tsrc_rdy_n === 1'b0) tx_cnt++;
    if (reg_rd_en === 1'b1) rd_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] req_b0(input logic [6:0] ft, input logic [9:0] len,
      input logic [2:0] tc, input logic [1:0] attr, input logic [15:0] rid,
      input logic [7:0] tag, input logic [3:0] be);
    return {1'b0, ft, 1'b0, tc, 4'b0, 1'b0, 1'b0, attr, 2'b0, len, rid, tag, 4'h0, be};
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] d);
    logic [31:0] s;
    for (int i = 0; i < 4; i++) s[8*(3-i) +: 8] = d[8*i +: 8];
    return s;
  endfunction

  // Reference: byte count spans first..last enabled byte; offset is the first enabled byte
  function automatic logic [63:0] cpl_beat0(input logic [2:0] tc, input logic [1:0] attr,
                                            input logic [3:0] be);
    int lo = -1;
    int hi = -1;
    int bc;
    for (int i = 0; i < 4; i++) if (be[i]) begin
      if (lo < 0) lo = i;
      hi = i;
    end
    bc = (lo < 0) ? 1 : hi - lo + 1;
    return {32'h4A000001 | (32'(tc) << 20) | (32'(attr) << 12), cfg_completer_id, 16'(bc)};
  endfunction

  function automatic logic [63:0] cpl_beat1(input logic [15:0] rid, input logic [7:0] tag,
      input logic [31:0] addr, input logic [3:0] be, input logic [31:0] d);
    int lo = 0;
    for (int i = 3; i >= 0; i--) if (be[i]) lo = i;
    return {rid, tag, 8'((addr & 32'h7C) + 32'(lo)), bswap(d)};
  endfunction

  task automatic send_tlp(input logic [63:0] b0, input logic [63:0] b1,
                          input logic hit, input logic dsc);
    int n = 0;
    while (trn_rdst_rdy_n !== 1'b0 && n < 100) begin @(negedge trn_clk); n++; end
    check("rx_ready", trn_rdst_rdy_n, 1'b0);
    trn_rbar_hit_n = hit ? 7'h7E : 7'h7D;
    trn_rd = b0; trn_rsof_n = 1'b0; trn_reof_n = 1'b1; trn_rsrc_rdy_n = 1'b0;
    @(negedge trn_clk);
    trn_rd = b1; trn_rsof_n = 1'b1; trn_reof_n = 1'b0; trn_rsrc_dsc_n = !dsc;
    @(negedge trn_clk);
    trn_rsrc_rdy_n = 1'b1; trn_reof_n = 1'b1; trn_rsrc_dsc_n = 1'b1;
    trn_rd = '0; trn_rbar_hit_n = 7'h7F;
  endtask

  // Called at the negedge one cycle after the EOF beat was accepted
  task automatic expect_cpl(input string tag, input logic [63:0] e0, input logic [63:0] e1,
                            input int stall0, input int stall1, input int exp_lat);
    int n = 1;
    while (trn_tsof_n !== 1'b0 && n < 300) begin @(negedge trn_clk); n++; end
    check({tag, "_sof"}, trn_tsof_n, 1'b0);
    if (exp_lat > 0) check({tag, "_lat"}, n, exp_lat);
    for (int s = 0; s <= stall0; s++) begin
      check({tag, "_b0"}, trn_td, e0);
      check({tag, "_b0ctl"}, {trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, tx_req, trn_rdst_rdy_n},
            5'b01011);
      trn_tdst_rdy_n = (s < stall0);
      @(negedge trn_clk);
    end
    for (int s = 0; s <= stall1; s++) begin
      check({tag, "_b1"}, trn_td, e1);
      check({tag, "_b1ctl"}, {trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, tx_req, trn_rdst_rdy_n,
            trn_trem_n}, {5'b10011, 8'h00});
      trn_tdst_rdy_n = (s < stall1);
      @(negedge trn_clk);
    end
    check({tag, "_end"}, {trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, tx_req, trn_rdst_rdy_n},
          5'b11100);
    trn_tdst_rdy_n = 1'b0;
  endtask

  initial begin
    int n;
    int bad;
    int base;
    logic [31:0] a;
    logic [3:0]  be;
    logic [7:0]  tg;
    logic [15:0] rid;
    logic [2:0]  tc;
    logic [1:0]  at;

    trn_reset = 1'b1; trn_lnk_up_n = 1'b0; trn_rd = '0; trn_rrem_n = 8'h00;
    trn_rsof_n = 1'b1; trn_reof_n = 1'b1; trn_rsrc_rdy_n = 1'b1; trn_rsrc_dsc_n = 1'b1;
    trn_rbar_hit_n = 7'h7F; trn_tdst_rdy_n = 1'b0; trn_tbuf_av = 4'hF;
    cfg_completer_id = 16'h0208; tx_gnt = 1'b1;
    for (int i = 0; i < 8; i++) begin pv[i] = 1'b0; pa[i] = '0; end
    for (int i = 0; i < 1024; i++) regs[i] = $urandom;

    repeat (3) @(negedge trn_clk);
    check("rst_ctl", {trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, tx_req, trn_rdst_rdy_n,
          reg_rd_en, unsupported_req}, 7'b1110000);
    check("rst_td", trn_td, 64'h0);
    check("rst_trem", trn_trem_n, 8'hFF);
    check("rst_addr", reg_rd_addr, 10'h0);
    trn_reset = 1'b0;
    @(negedge trn_clk);

    // Basic MRd32, full BE
    regs[4] = 32'h11223344;
    send_tlp(req_b0(FT_MRD32, 10'd1, 3'd0, 2'd0, 16'h0100, 8'h05, 4'hF), {32'h10, 32'h0}, 1, 0);
    exp_reads++;
    expect_cpl("t1", {32'h4A000001, 16'h0208, 16'h0004}, 64'h01000510_44332211, 0, 0, L + 3);

    // Single byte at offset 1
    send_tlp(req_b0(FT_MRD32, 10'd1, 3'd0, 2'd0, 16'h1234, 8'h3C, 4'b0010), {32'h24, 32'h0}, 1, 0);
    exp_reads++;
    expect_cpl("t2", {32'h4A000001, 16'h0208, 16'h0001},
               {16'h1234, 8'h3C, 8'h25, bswap(regs[9])}, 0, 0, L + 3);

    // Completion buffer unavailable, then Tx backpressure on both beats
    trn_tbuf_av = 4'hB;
    send_tlp(req_b0(FT_MRD32, 10'd1, 3'd5, 2'd2, 16'hA5A5, 8'h77, 4'b1100), {32'h1FC, 32'h0}, 1, 0);
    exp_reads++;
    repeat (L + 3) @(negedge trn_clk);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (trn_tsof_n !== 1'b1 || tx_req !== 1'b1 || trn_tsrc_rdy_n !== 1'b1) bad++;
      @(negedge trn_clk);
    end
    check("t3_hold", bad, 0);
    trn_tbuf_av = 4'hF;
    expect_cpl("t3", cpl_beat0(3'd5, 2'd2, 4'b1100),
               cpl_beat1(16'hA5A5, 8'h77, 32'h1FC, 4'b1100, regs[127]), 2, 1, -1);

    // Rejected reads pulse unsupported_req; other traffic is ignored
    base = tx_cnt; n = rd_cnt; bad = ur_cnt;
    send_tlp(req_b0(FT_MRD32, 10'd2, 3'd0, 2'd0, 16'h1, 8'h1, 4'hF), {32'h40, 32'h0}, 1, 0);
    send_tlp(req_b0(FT_MRD64, 10'd1, 3'd0, 2'd0, 16'h1, 8'h2, 4'hF), {32'h1, 32'h40}, 1, 0);
    send_tlp(req_b0(FT_MWR32, 10'd1, 3'd0, 2'd0, 16'h1, 8'h3, 4'hF), {32'h40, 32'h5}, 1, 0);
    send_tlp(req_b0(FT_MRD32, 10'd1, 3'd0, 2'd0, 16'h1, 8'h4, 4'hF), {32'h40, 32'h0}, 0, 0);
    repeat (12) @(negedge trn_clk);
    check("t4_ur", ur_cnt - bad, 2);
    check("t4_tx", tx_cnt - base, 0);
    check("t4_rd", rd_cnt - n, 0);

    // Discontinued request is dropped, the following one completes
    base = tx_cnt; n = rd_cnt;
    send_tlp(req_b0(FT_MRD32, 10'd1, 3'd0, 2'd0, 16'h2, 8'h9, 4'hF), {32'h80, 32'h0}, 1, 1);
    repeat (12) @(negedge trn_clk);
    check("t5_tx", tx_cnt - base, 0);
    check("t5_rd", rd_cnt - n, 0);
    send_tlp(req_b0(FT_MRD32, 10'd1, 3'd1, 2'd1, 16'h0003, 8'h0A, 4'b0111), {32'h84, 32'h0}, 1, 0);
    exp_reads++;
    expect_cpl("t5", cpl_beat0(3'd1, 2'd1, 4'b0111),
               cpl_beat1(16'h0003, 8'h0A, 32'h84, 4'b0111, regs[33]), 0, 0, L + 3);

    // Reset while the second Tx beat is pending
    send_tlp(req_b0(FT_MRD32, 10'd1, 3'd0, 2'd0, 16'h4, 8'h0B, 4'hF), {32'hC0, 32'h0}, 1, 0);
    exp_reads++;
    n = 0;
    while (trn_tsof_n !== 1'b0 && n < 300) begin @(negedge trn_clk); n++; end
    check("t6_sof", trn_tsof_n, 1'b0);
    @(negedge trn_clk);
    check("t6_tx1", {trn_teof_n, trn_tsrc_rdy_n}, 2'b00);
    trn_tdst_rdy_n = 1'b1;
    trn_reset = 1'b1;
    @(negedge trn_clk);
    check("t6_rst", {trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, tx_req, trn_rdst_rdy_n}, 5'b11100);
    check("t6_td", trn_td, 64'h0);
    trn_reset = 1'b0;
    trn_tdst_rdy_n = 1'b0;
    @(negedge trn_clk);
    send_tlp(req_b0(FT_MRD32, 10'd1, 3'd0, 2'd0, 16'h5, 8'h0C, 4'b1000), {32'hC4, 32'h0}, 1, 0);
    exp_reads++;
    expect_cpl("t6", cpl_beat0(3'd0, 2'd0, 4'b1000),
               cpl_beat1(16'h5, 8'h0C, 32'hC4, 4'b1000, regs[49]), 0, 0, L + 3);

    // Randomized requests with random Tx stalls
    for (int k = 0; k < 16; k++) begin
      a   = $urandom & 32'hFFFF_FFFC;
      be  = 4'($urandom);
      tg  = 8'($urandom);
      rid = 16'($urandom);
      tc  = 3'($urandom);
      at  = 2'($urandom);
      cfg_completer_id = 16'($urandom);
      send_tlp(req_b0(FT_MRD32, 10'd1, tc, at, rid, tg, be), {a, 32'($urandom)}, 1, 0);
      exp_reads++;
      expect_cpl("rnd", cpl_beat0(tc, at, be), cpl_beat1(rid, tg, a, be, regs[a[11:2]]),
                 $urandom_range(0, 2), $urandom_range(0, 2), L + 3);
    end

    check("rd_strobes", rd_cnt, exp_reads);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
